// File: rtl/sensor_frame_scheduler_pkg.sv
// Shared types and constants for the sensor frame scheduler.
package sensor_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT,
        ST_SEND,
        ST_CSUM
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // Bytes per frame: sync + one per bank address + checksum.
    function automatic int frame_len(input logic [7:0] first, input logic [7:0] last);
        return int'(last) - int'(first) + 3;
    endfunction

endpackage

// File: rtl/sensor_frame_scheduler_if.sv
// Valid/ready byte stream from the frame scheduler to the telemetry sink.
interface sensor_frame_scheduler_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sensor_frame_csum.sv
// Running frame checksum: two's-complement sum by default, CRC-8 (poly 0x07)
// when SENSOR_FRAME_CRC8_EN is defined.
module sensor_frame_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic [7:0] o_check
);

    logic [7:0] r_acc;
    logic [7:0] w_acc_nxt;

`ifdef SENSOR_FRAME_CRC8_EN
    import sensor_frame_scheduler_pkg::*;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_acc_nxt = crc8_step(r_acc, i_byte);
    assign o_check   = r_acc;
`else
    assign w_acc_nxt = r_acc + i_byte;
    // Negated sum, so payload bytes plus this byte add to zero mod 256.
    assign o_check   = ~r_acc + 8'd1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= 8'h00;
        end else if (i_valid) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/sensor_frame_scheduler.sv
// Periodic sensor-bank readout sequencer emitting sync/payload/checksum frames.
// Optional CRC-8 checksum selected by SENSOR_FRAME_CRC8_EN.
module sensor_frame_scheduler
    import sensor_frame_scheduler_pkg::*;
#(
    parameter logic [7:0]  FIRST_ADDR = 8'd1,
    parameter logic [7:0]  LAST_ADDR  = 8'd25,
    parameter int unsigned PERIOD     = 1000,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    sensor_frame_scheduler_if.master tx,
    input  logic                     i_enable,
    output logic [7:0]               o_reg_addr,
    input  logic [7:0]               i_reg_data,
    output logic                     o_frame_busy,
    output logic                     o_frame_done,
    output logic [7:0]               o_overrun_cnt
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic [7:0]       r_overrun;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_tx_valid, w_tx_valid_nxt;
    logic [7:0]       r_addr, w_addr_nxt;
    logic             r_done, w_done_nxt;
    logic             w_tick, w_accept, w_consume, w_csum_clear, w_csum_valid;
    logic [7:0]       w_check;

    assign w_tick   = i_enable && (r_cnt == '0);
    assign w_accept = r_tx_valid && tx.tx_ready;

    sensor_frame_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_csum_clear),
        .i_valid (w_csum_valid),
        .i_byte  (i_reg_data),
        .o_check (w_check)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= RELOAD;
            r_pending <= 1'b0;
            r_overrun <= 8'h00;
        end else begin
            r_cnt <= (!i_enable || r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
            // A tick always leaves a frame pending; one arriving on top of
            // an already pending tick is counted as dropped.
            if (w_tick) begin
                r_pending <= 1'b1;
                if (r_pending && r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_addr     <= 8'h00;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_addr     <= w_addr_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_addr_nxt     = r_addr;
        w_done_nxt     = 1'b0;
        w_consume      = 1'b0;
        w_csum_clear   = 1'b0;
        w_csum_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_addr_nxt     = 8'h00;
                w_tx_valid_nxt = 1'b0;
                if (r_pending) begin
                    w_consume      = 1'b1;
                    w_csum_clear   = 1'b1;
                    w_tx_data_nxt  = SYNC_BYTE;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_accept) begin
                    w_addr_nxt     = FIRST_ADDR;
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_tx_data_nxt  = i_reg_data;
                w_tx_valid_nxt = 1'b1;
                w_csum_valid   = 1'b1;
                w_state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                if (w_accept) begin
                    if (r_addr == LAST_ADDR) begin
                        w_tx_data_nxt = w_check;
                        w_state_nxt   = ST_CSUM;
                    end else begin
                        w_addr_nxt     = r_addr + 8'd1;
                        w_tx_valid_nxt = 1'b0;
                        w_state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    w_tx_valid_nxt = 1'b0;
                    w_addr_nxt     = 8'h00;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign tx.tx_data    = r_tx_data;
    assign tx.tx_valid   = r_tx_valid;
    assign o_reg_addr    = r_addr;
    assign o_frame_busy  = (r_state != ST_IDLE);
    assign o_frame_done  = r_done;
    assign o_overrun_cnt = r_overrun;

endmodule

// File: tb/tb_sensor_frame_scheduler.sv
// Directed bench for sensor_frame_scheduler: bank tied data=addr, PERIOD=100.
module tb_sensor_frame_scheduler;
    import sensor_frame_scheduler_pkg::*;

    localparam int         PERIOD = 100;
    localparam logic [7:0] FIRST  = 8'd1;
    localparam logic [7:0] LAST   = 8'd25;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;
    logic [7:0] overrun;

    sensor_frame_scheduler_if bus ();

    always #5 clk = ~clk;
    assign reg_data = reg_addr;

    sensor_frame_scheduler #(
        .FIRST_ADDR (FIRST),
        .LAST_ADDR  (LAST),
        .PERIOD     (PERIOD),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx            (bus),
        .i_enable      (enable),
        .o_reg_addr    (reg_addr),
        .i_reg_data    (reg_data),
        .o_frame_busy  (busy),
        .o_frame_done  (done),
        .o_overrun_cnt (overrun)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] rx_bytes [64];
    int         nbytes;
    int         cycles;
    int         busy_cnt;
    int         n;
    bit         stable_ok;
    logic [7:0] exp_csum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

`ifdef SENSOR_FRAME_CRC8_EN
    // Bit-serial CRC-8, poly 0x07, init 0, MSB first.
    function automatic logic [7:0] ref_crc8();
        logic [7:0] crc;
        logic [7:0] d;
        logic       fb;
        crc = 8'h00;
        for (int a = int'(FIRST); a <= int'(LAST); a++) begin
            d = 8'(a);
            for (int b = 7; b >= 0; b--) begin
                fb  = crc[7] ^ d[b];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction
`endif

    task automatic check_reset_state(input string tag);
        check({tag, ".reg_addr"}, 32'(reg_addr), 32'h0);
        check({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'h0);
        check({tag, ".tx_data"}, 32'(bus.tx_data), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
        check({tag, ".overrun"}, 32'(overrun), 32'h0);
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!bus.tx_valid && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic rx_frame(input bit throttle);
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        bit         seen_done;
        cyc = 0; prev_stall = 0; prev_data = 8'h00; seen_done = 0;
        nbytes = 0; busy_cnt = 0; stable_ok = 1; cycles = 0;
        while (!seen_done && cyc < 2000) begin
            bus.tx_ready = throttle ? (cyc % 3 == 0) : 1'b1;
            if (done) begin
                seen_done = 1;
                cycles    = cyc;
            end else begin
                if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) stable_ok = 0;
                if (bus.tx_valid && bus.tx_ready && nbytes < 64) begin
                    rx_bytes[nbytes] = bus.tx_data;
                    nbytes++;
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data  = bus.tx_data;
                if (busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        check("rx_frame_done_seen", 32'(seen_done), 32'h1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, ".len"}, 32'(nbytes), 32'(frame_len(FIRST, LAST)));
        check({tag, ".sync"}, 32'(rx_bytes[0]), 32'hA5);
        for (int k = 1; k <= 25; k++) begin
            check($sformatf("%s.payload%0d", tag, k), 32'(rx_bytes[k]), 32'(k));
        end
        check({tag, ".csum"}, 32'(rx_bytes[26]), 32'(exp_csum));
    endtask

    task automatic accept_n(input int cnt);
        int got;
        int guard;
        got = 0; guard = 0;
        bus.tx_ready = 1'b1;
        while (got < cnt && guard < 1000) begin
            if (bus.tx_valid) got++;
            @(negedge clk);
            guard++;
        end
        bus.tx_ready = 1'b0;
        check("accept_n_count", 32'(got), 32'(cnt));
    endtask

    initial begin
`ifdef SENSOR_FRAME_CRC8_EN
        exp_csum = ref_crc8();
`else
        exp_csum = 8'hBB;  // 1+..+25 = 0x145 -> 0x45 -> 0xBB
`endif
        rst = 1'b1;
        enable = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // enable low: no frames at all
        n = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.tx_valid) n++;
        end
        check("disabled_no_valid", 32'(n), 32'h0);

        // tick after PERIOD enabled edges, SYNC one edge later
        enable = 1'b1;
        wait_valid(300, n);
        check("first_sync_delay", 32'(n), 32'(PERIOD + 1));

        rx_frame(1'b0);
        check_frame("f1");
        check("f1_busy_cycles", 32'(busy_cnt), 32'd52);
        check("f1_done_latency", 32'(cycles), 32'd52);
        wait_valid(300, n);
        check("f1_sync_to_sync", 32'(cycles + n), 32'(PERIOD));

        // ready 1-of-3: same bytes, stable under backpressure
        rx_frame(1'b1);
        check_frame("f2");
        check("f2_stable", 32'(stable_ok), 32'h1);
        check("f2_overrun", 32'(overrun), 32'h0);
        wait_valid(300, n);
        check("f2_sync_to_sync", 32'(cycles + n), 32'(PERIOD));

        // 300-cycle stall mid-frame spans three ticks: one queued, two dropped
        accept_n(10);
        repeat (300) @(negedge clk);
        check("stall_overrun", 32'(overrun), 32'd2);
        check("stall_hold_valid", 32'(bus.tx_valid), 32'h1);
        check("stall_hold_data", 32'(bus.tx_data), 32'h0A);
        rx_frame(1'b0);
        check("stall_rest_len", 32'(nbytes), 32'd17);
        check("stall_rest_first", 32'(rx_bytes[0]), 32'h0A);
        check("stall_rest_csum", 32'(rx_bytes[16]), 32'(exp_csum));
        wait_valid(10, n);
        check("queued_start", 32'(n), 32'd1);
        rx_frame(1'b0);
        check_frame("f4");
        check("f4_overrun", 32'(overrun), 32'd2);

        // long stall: ~300 dropped ticks saturate the counter
        wait_valid(300, n);
        check("f5_start_found", 32'(bus.tx_valid), 32'h1);
        accept_n(10);
        repeat (30000) @(negedge clk);
        check("sat_overrun", 32'(overrun), 32'd255);
        check("sat_hold_data", 32'(bus.tx_data), 32'h0A);
        check("sat_busy", 32'(busy), 32'h1);

        // reset during byte 10 truncates the frame
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        wait_valid(300, n);
        check("post_reset_sync_delay", 32'(n), 32'(PERIOD + 1));
        rx_frame(1'b0);
        check_frame("f6");
        check("f6_busy_cycles", 32'(busy_cnt), 32'd52);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sensor_frame_scheduler.md
Name: sensor_frame_scheduler

Overview:
- Periodic readout sequencer for the sensor register bank (8-bit addr in, 8-bit data out, addresses 1..25).
- On each frame tick, walks the bank address range and emits a byte stream: sync byte, payload bytes, checksum.
- The stream goes over a valid/ready handshake to the telemetry UART/radio.
- It is the only master of the bank's addr port.

Parameters:
- FIRST_ADDR, 8'd1, first bank address read per frame.
- LAST_ADDR, 8'd25, last bank address read per frame (must be ≥ FIRST_ADDR).
- PERIOD, 1000, clk cycles between frame ticks (must be ≥ 2*(LAST_ADDR-FIRST_ADDR+1)+4).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  runs the period counter; 0 means no new ticks.
- reg_addr  out  8  address to the sensor register bank.
- reg_data  in  8  bank read data; valid the cycle after reg_addr changes.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts a byte on a cycle where tx_valid && tx_ready.
- frame_busy  out  1  high from SYNC through CSUM.
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted.
- overrun_cnt  out  8  count of ticks dropped because one was already pending; saturates at 255.

Behaviour:
- Reset values: every output is 0, state=IDLE, period counter=PERIOD-1, pending=0, csum=0.
- Period counter: decrements while enable=1. At 0 it reloads PERIOD-1 and raises tick for one cycle. When enable=0 it holds at PERIOD-1.
- Tick handling: sets pending. If pending is already 1 on that cycle, pending stays 1 and overrun_cnt increments (saturating).
- States: IDLE, SYNC, WAIT, SEND, CSUM.
- IDLE: reg_addr=0, tx_valid=0. If pending, clear pending, csum<=0, tx_data<=SYNC_BYTE, tx_valid<=1, go to SYNC.
- SYNC: on accept, reg_addr<=FIRST_ADDR, tx_valid<=0, go to WAIT.
- WAIT (exactly 1 cycle): tx_data<=reg_data, tx_valid<=1, csum<=csum+reg_data (mod 256), go to SEND.
- SEND: on accept at reg_addr==LAST_ADDR, tx_data<=checksum and go to CSUM with tx_valid held at 1. On accept otherwise, reg_addr<=reg_addr+1, tx_valid<=0, go to WAIT.
- CSUM: on accept, tx_valid<=0, reg_addr<=0, frame_done<=1 for one cycle, go to IDLE.
- Checksum: the SYNC byte is excluded. Without CRC8_EN the transmitted byte is the two's complement of the sum (~csum+1), so sum(payload)+checksum == 0 mod 256.
- Handshake: while tx_valid && !tx_ready, tx_data and tx_valid stay stable and the state holds. Backpressure has no bound.
- Latency with tx_ready tied to 1 and default params:
  - SYNC is accepted 1 cycle after IDLE sees pending.
  - Each payload byte takes 2 cycles.
  - Frame is 27 bytes, 52 busy cycles, then frame_done.
- frame_busy = (state != IDLE).
- Simultaneous events:
  - A tick on the same cycle as frame_done sets pending; the next frame starts from IDLE on the following cycle.
  - A tick during IDLE with pending=0 is not an overrun.
- Reset mid-frame: the next edge returns to the reset state. The frame is truncated with no checksum, and overrun_cnt is cleared.
- enable falling mid-frame: the current frame completes; pending stays as is.

Optional Feature:
- Macro: SENSOR_FRAME_CRC8_EN.
- Defined: the checksum byte is CRC-8 over the payload bytes (poly 0x07, init 0x00, MSB first, no reflection, no final xor), computed bytewise in WAIT.
- Undefined: two's-complement sum as above.
- Cycle timing is identical in both builds.

Decomposition:
- Shared package: state enum (IDLE/SYNC/WAIT/SEND/CSUM), SYNC_BYTE default, CRC8 polynomial constant, frame-length function (LAST-FIRST+3).
- One sub-module: sensor_frame_csum (clear, byte-valid, byte in → running value out; sum or CRC selected by the macro).

Test Plan:
- Bank tied so data=addr, tx_ready=1, PERIOD=100, enable=1: first tick at cycle 100 → bytes A5, 01..19 (hex), checksum 0xBB (sum 0x145 → 0x45 → 0xBB). frame_done 52 cycles after SYNC, then next frame at cycle 200.
- Same setup with tx_ready toggling 1-of-3 cycles → identical byte sequence; tx_data stable whenever valid && !ready.
- tx_ready=0 held for 3*PERIOD mid-frame → overrun_cnt=2, exactly one frame queued afterwards; after 300 dropped ticks overrun_cnt=255.
- rst asserted for 1 cycle during byte 10 → all outputs 0 next cycle, no checksum emitted, next tick produces a full clean frame.
- SENSOR_FRAME_CRC8_EN defined, data=addr → checksum equals a reference-model CRC-8 of 01..19; byte count and timing unchanged.
- enable=0 from reset for 500 cycles → no tx_valid; enable=1 → first SYNC PERIOD cycles later.
